ula: RTL and testbench

- Parameterizable bit-slice arithmetic/logic unit for the MIPS datapath.
- Default WIDTH=1 is one ALU slice; wider instances are a ripple chain of slices.
- Combinational result path, plus a registered copy of result and flags for pipelined consumers.
- Carry-in and add/subtract control are external, so slices can be chained.

---
 rtl/ula_pkg.sv | 17 +
 rtl/ula_fa.sv | 13 +
 rtl/ula.sv | 83 ++++++++
 tb/tb_ula.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared operation encoding and widths for the ula bit-slice ALU.
package ula_pkg;

    localparam int unsigned ULA_OP_W = 3;

    typedef enum logic [ULA_OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_SUM   = 3'b010,
        OP_XOR   = 3'b011,
        OP_NOR   = 3'b100,
        OP_PASSA = 3'b101,
        OP_PASSB = 3'b110,
        OP_SLT   = 3'b111
    } ula_op_e;

endpackage

// File: rtl/ula_fa.sv
// One-bit full adder; the ula carry chain is a ripple of these cells.
module ula_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/ula.sv
// Bit-slice ALU with combinational result/flags and a registered copy.
// Define ULA_SLT_EN to enable signed set-less-than on op 111.
module ula
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ULA_OP_W-1:0] ULAcontrole,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cin,
    input  logic                addsub,
    output logic [WIDTH-1:0]    ULAsaida,
    output logic                cout,
    output logic                zero,
    output logic [WIDTH-1:0]    ULAsaida_q,
    output logic                cout_q,
    output logic                zero_q
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] sum;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] slt_val;
    ula_op_e          op;

    assign op   = ula_op_e'(ULAcontrole);
    assign bx   = b ^ {WIDTH{addsub}};
    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        ula_fa u_fa (
            .a    (a[i]),
            .b    (bx[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

`ifdef ULA_SLT_EN
    // Sign of the result corrected by the overflow bit of the last stage.
    always_comb begin
        slt_val    = '0;
        slt_val[0] = sum[WIDTH-1] ^ c[WIDTH] ^ c[WIDTH-1];
    end
`else
    assign slt_val = '0;
`endif

    always_comb begin
        ULAsaida = '0;
        unique case (op)
            OP_AND:   ULAsaida = a & b;
            OP_OR:    ULAsaida = a | b;
            OP_SUM:   ULAsaida = sum;
            OP_XOR:   ULAsaida = a ^ b;
            OP_NOR:   ULAsaida = ~(a | b);
            OP_PASSA: ULAsaida = a;
            OP_PASSB: ULAsaida = b;
            OP_SLT:   ULAsaida = slt_val;
            default:  ULAsaida = '0;
        endcase
    end

    assign cout = c[WIDTH];
    assign zero = ~|ULAsaida;

    always_ff @(posedge clk) begin
        if (rst) begin
            ULAsaida_q <= '0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            ULAsaida_q <= ULAsaida;
            cout_q     <= cout;
            zero_q     <= zero;
        end
    end

endmodule

// File: tb/tb_ula.sv
// Directed scoreboard bench for ula at WIDTH=1 (exhaustive) and WIDTH=8.
module tb_ula;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op;
    logic       cin, addsub;
    logic [0:0] a1, b1, r1, r1_q;
    logic       co1, z1, co1_q, z1_q;
    logic [7:0] a8, b8, r8, r8_q;
    logic       co8, z8, co8_q, z8_q;

    int checks = 0;
    int errors = 0;

    exp_t comb_q[$];
    exp_t reg_q[$];

    always #5 clk = ~clk;

    ula #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .ULAcontrole(op), .a(a1), .b(b1), .cin(cin), .addsub(addsub),
        .ULAsaida(r1), .cout(co1), .zero(z1), .ULAsaida_q(r1_q), .cout_q(co1_q), .zero_q(z1_q)
    );

    ula #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .ULAcontrole(op), .a(a8), .b(b8), .cin(cin), .addsub(addsub),
        .ULAsaida(r8), .cout(co8), .zero(z8), .ULAsaida_q(r8_q), .cout_q(co8_q), .zero_q(z8_q)
    );

    // Integer reference model; SLT is the sign of the exact signed sum.
    function automatic exp_t model(int w, logic [2:0] o, int av, int bv, int ci, int as);
        exp_t e;
        int   mask, bx, full, sa, sbx, res;
        mask = (1 << w) - 1;
        bx   = (as != 0) ? (~bv & mask) : bv;
        full = av + bx + ci;
        sa   = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sbx  = (bx >= (1 << (w - 1))) ? bx - (1 << w) : bx;
        case (o)
            3'b000: res = av & bv;
            3'b001: res = av | bv;
            3'b010: res = full & mask;
            3'b011: res = av ^ bv;
            3'b100: res = ~(av | bv) & mask;
            3'b101: res = av;
            3'b110: res = bv;
`ifdef ULA_SLT_EN
            default: res = (sa + sbx + ci < 0) ? 1 : 0;
`else
            default: res = 0;
`endif
        endcase
        e.res  = 8'(res);
        e.cout = ((full >> w) & 1) != 0;
        e.zero = (res == 0);
        return e;
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag, int w, logic [2:0] o, int av, int bv, logic ci, logic as);
        exp_t e;
        op = o; cin = ci; addsub = as;
        if (w == 1) begin a1 = 1'(av); b1 = 1'(bv); end
        else begin a8 = 8'(av); b8 = 8'(bv); end
        e = model(w, o, av, bv, int'(ci), int'(as));
        comb_q.push_back(e);
        reg_q.push_back(e);
        #1;
        e = comb_q.pop_front();
        if (w == 1) begin
            chk({tag, ".res"}, 8'(r1), e.res);
            chk({tag, ".cout"}, 8'(co1), 8'(e.cout));
            chk({tag, ".zero"}, 8'(z1), 8'(e.zero));
        end else begin
            chk({tag, ".res"}, r8, e.res);
            chk({tag, ".cout"}, 8'(co8), 8'(e.cout));
            chk({tag, ".zero"}, 8'(z8), 8'(e.zero));
        end
        @(posedge clk); #1;
        e = reg_q.pop_front();
        if (w == 1) begin
            chk({tag, ".res_q"}, 8'(r1_q), e.res);
            chk({tag, ".cout_q"}, 8'(co1_q), 8'(e.cout));
            chk({tag, ".zero_q"}, 8'(z1_q), 8'(e.zero));
        end else begin
            chk({tag, ".res_q"}, r8_q, e.res);
            chk({tag, ".cout_q"}, 8'(co8_q), 8'(e.cout));
            chk({tag, ".zero_q"}, 8'(z8_q), 8'(e.zero));
        end
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; op = '0; cin = 1'b0; addsub = 1'b0;
        a1 = '0; b1 = '0; a8 = '0; b8 = '0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst.r1_q", 8'(r1_q), 8'h00);
        chk("rst.co1_q", 8'(co1_q), 8'h00);
        chk("rst.z1_q", 8'(z1_q), 8'h00);
        chk("rst.r8_q", r8_q, 8'h00);
        chk("rst.co8_q", 8'(co8_q), 8'h00);
        chk("rst.z8_q", 8'(z8_q), 8'h00);
        rst = 1'b0;

        // Spot values from hand calculation before the exhaustive sweep.
        step("w1.sub_ex", 1, 3'b010, 1, 0, 1'b1, 1'b1);
        chk("w1.sub_ex.const", 8'(r1_q), 8'h01);
        step("w1.and_ex", 1, 3'b000, 1, 1, 1'b0, 1'b0);
        chk("w1.and_ex.const", 8'(r1_q), 8'h01);
        step("w1.nor_ex", 1, 3'b100, 0, 0, 1'b0, 1'b0);
        chk("w1.nor_ex.const", 8'(r1_q), 8'h01);

        for (int v = 0; v < 128; v++)
            step($sformatf("w1.v%0d", v), 1, 3'(v >> 4), (v >> 3) & 1, (v >> 2) & 1,
                 1'(v >> 1), 1'(v));

        step("w8.add_wrap", 8, 3'b010, 8'hFF, 8'h01, 1'b0, 1'b0);
        chk("w8.add_wrap.const", r8_q, 8'h00);
        chk("w8.add_wrap.coutc", 8'(co8_q), 8'h01);
        step("w8.sub", 8, 3'b010, 5, 7, 1'b1, 1'b1);
        chk("w8.sub.const", r8_q, 8'hFE);
        step("w8.slt_ovf", 8, 3'b111, 8'h80, 8'h01, 1'b1, 1'b1);
        step("w8.slt_gt", 8, 3'b111, 8'h05, 8'h03, 1'b1, 1'b1);
        step("w8.slt_lt", 8, 3'b111, 8'h03, 8'h05, 1'b1, 1'b1);
        step("w8.and_raw_b", 8, 3'b000, 8'hF0, 8'hFF, 1'b0, 1'b1);
        chk("w8.and_raw_b.const", r8_q, 8'hF0);
        step("w8.xor", 8, 3'b011, 8'h3C, 8'h0F, 1'b0, 1'b0);
        step("w8.passb", 8, 3'b110, 8'h12, 8'h34, 1'b0, 1'b0);

        step("w8.load", 8, 3'b101, 8'hAA, 8'h00, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("w8.rst.res_q", r8_q, 8'h00);
        chk("w8.rst.cout_q", 8'(co8_q), 8'h00);
        chk("w8.rst.zero_q", 8'(z8_q), 8'h00);
        chk("w8.rst.comb", r8, 8'hAA);
        rst = 1'b0;
        reg_q.push_back(model(8, 3'b101, 8'hAA, 0, 0, 0));
        @(posedge clk); #1;
        e = reg_q.pop_front();
        chk("w8.resume.res_q", r8_q, e.res);
        chk("w8.resume.cout_q", 8'(co8_q), 8'(e.cout));
        chk("w8.resume.zero_q", 8'(z8_q), 8'(e.zero));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
